// File: rtl/dlatch_bist.sv
// dlatch_bist: self-test engine for a D-latch cell. It drives c/d from an LFSR, tracks q in a golden model and counts q/qbar mismatches.
// Optional build macro DLATCH_BIST_STOP_ON_FAIL_EN: the run ends at the first mismatch, and the fail_out port reports it.
module dlatch_bist #(
  parameter int          NUM_STEPS = 32,
  parameter int          SETTLE    = 2,
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter int          ERR_W     = 8,
  localparam int         STEP_W    = $clog2(NUM_STEPS)
) (
  input  logic              clk_in,
  input  logic              rstn_in,
  input  logic              start_in,
  input  logic              q_in,
  input  logic              qbar_in,
  output logic              c_out,
  output logic              d_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              pass_out,
  output logic [ERR_W-1:0]  err_cnt_out,
  output logic [STEP_W-1:0] step_out
`ifdef DLATCH_BIST_STOP_ON_FAIL_EN
  ,
  output logic              fail_out
`endif
);

  localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, shifting toward bit 0
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    lfsr_next = {v[0] ^ v[2] ^ v[3] ^ v[4], v[7:1]};
  endfunction

  state_t              state_q, state_d;
  logic [7:0]          lfsr_q, lfsr_d;
  logic                model_q, model_d;
  logic                c_q, c_d;
  logic                d_q, d_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                mismatch_s;
  logic [ERR_W-1:0]    err_inc_s;

  assign mismatch_s = (q_in != model_q) || (qbar_in != ~model_q);
  assign err_inc_s  = (err_q == ERR_MAX) ? err_q : err_q + {{(ERR_W-1){1'b0}}, 1'b1};

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    model_d = model_q;
    c_d     = c_q;
    d_d     = d_q;
    step_d  = step_q;
    err_d   = err_q;
    wait_d  = wait_q;
    fail_d  = fail_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_in) begin
          state_d = ST_APPLY;
          step_d  = {STEP_W{1'b0}};
          err_d   = {ERR_W{1'b0}};
          lfsr_d  = LFSR_SEED;
          wait_d  = {WAIT_W{1'b0}};
          fail_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_APPLY: begin
        // Step 0 loads a known 0 into the latch before random stimulus begins
        if (step_q == {STEP_W{1'b0}}) begin
          c_d     = 1'b1;
          d_d     = 1'b0;
          model_d = 1'b0;
        end else begin
          c_d     = lfsr_q[0];
          d_d     = lfsr_q[1];
          lfsr_d  = lfsr_next(lfsr_q);
          model_d = lfsr_q[0] ? lfsr_q[1] : model_q;
        end
        wait_d  = {WAIT_W{1'b0}};
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_W'(SETTLE - 1)) begin
          state_d = ST_CHECK;
        end else begin
          wait_d = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_CHECK: begin
        if (mismatch_s) begin
          err_d = err_inc_s;
        end else begin
          err_d = err_q;
        end
`ifdef DLATCH_BIST_STOP_ON_FAIL_EN
        if (mismatch_s) begin
          state_d = ST_DONE;
          fail_d  = 1'b1;
          c_d     = 1'b0;
          d_d     = 1'b0;
        end else if (step_q == STEP_W'(NUM_STEPS - 1)) begin
`else
        if (step_q == STEP_W'(NUM_STEPS - 1)) begin
`endif
          state_d = ST_DONE;
          c_d     = 1'b0;
          d_d     = 1'b0;
        end else begin
          step_d  = step_q + {{(STEP_W-1){1'b0}}, 1'b1};
          state_d = ST_APPLY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        c_d     = 1'b0;
        d_d     = 1'b0;
      end
    endcase
    busy_d = (state_d == ST_APPLY) || (state_d == ST_WAIT) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
    pass_d = (state_d == ST_DONE) && (err_d == {ERR_W{1'b0}});
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      model_q <= 1'b0;
      c_q     <= 1'b0;
      d_q     <= 1'b0;
      step_q  <= {STEP_W{1'b0}};
      err_q   <= {ERR_W{1'b0}};
      wait_q  <= {WAIT_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      model_q <= model_d;
      c_q     <= c_d;
      d_q     <= d_d;
      step_q  <= step_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign c_out       = c_q;
  assign d_out       = d_q;
  assign busy_out    = busy_q;
  assign done_out    = done_q;
  assign pass_out    = pass_q;
  assign err_cnt_out = err_q;
  assign step_out    = step_q;
`ifdef DLATCH_BIST_STOP_ON_FAIL_EN
  assign fail_out    = fail_q;
`else
  logic unused_fail_s;
  assign unused_fail_s = fail_q;
`endif

endmodule

// File: tb/tb_dlatch_bist.sv
// Bench for dlatch_bist: behavioural latch, stuck-output and tied-qbar faults, mid-run reset and restart scenarios.
module tb_dlatch_bist;

  localparam int P     = 4;    // SETTLE + 2 cycles per step
  localparam int LIMIT = 300;

  logic       clk = 1'b0;
  logic       rstn, start, start3;
  logic       c, d, busy, done, pass;
  logic [7:0] err;
  logic [4:0] step;
  logic       c3, d3, busy3, done3, pass3;
  logic [2:0] err3;
  logic [4:0] step3;
  logic       fail, fail3;
  logic       lq, q_s, qbar_s;
  int         mode;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  always @(c or d) if (c) lq = d;
  assign q_s    = (mode == 1) ? 1'b0 : lq;
  assign qbar_s = (mode == 1) ? 1'b1 : ~lq;

  dlatch_bist dut (
    .clk_in(clk), .rstn_in(rstn), .start_in(start), .q_in(q_s), .qbar_in(qbar_s),
    .c_out(c), .d_out(d), .busy_out(busy), .done_out(done), .pass_out(pass),
    .err_cnt_out(err), .step_out(step)
`ifdef DLATCH_BIST_STOP_ON_FAIL_EN
    , .fail_out(fail)
`endif
  );

  dlatch_bist #(.ERR_W(3)) dut3 (
    .clk_in(clk), .rstn_in(rstn), .start_in(start3), .q_in(d3), .qbar_in(d3),
    .c_out(c3), .d_out(d3), .busy_out(busy3), .done_out(done3), .pass_out(pass3),
    .err_cnt_out(err3), .step_out(step3)
`ifdef DLATCH_BIST_STOP_ON_FAIL_EN
    , .fail_out(fail3)
`endif
  );

`ifndef DLATCH_BIST_STOP_ON_FAIL_EN
  assign fail  = 1'b0;
  assign fail3 = 1'b0;
`endif

  typedef struct {int step; bit c; bit d;} vec_t;
  typedef struct {
    int mode; bit pulse_mid; int abort_at;
    int exp_cycles; bit exp_pass; int exp_err; int exp_step; bit exp_fail;
  } scen_t;

  vec_t  vecs[14];
  scen_t scens[5];
  bit    ref_c[32], ref_d[32], ref_m[32];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_cd(input int k);
    if (k < 14) return k * 4 + int'(vecs[k].c) * 2 + int'(vecs[k].d);
    else        return k * 4 + int'(ref_c[k]) * 2 + int'(ref_d[k]);
  endfunction

  function automatic int all_outs();
    return int'({c, d, busy, done, pass, err, step, fail});
  endfunction

  task automatic do_run(input scen_t s, input int idx);
    int cyc;
    int k;
    int busy_bad;
    bit fin;
    string tag;
    tag = $sformatf("s%0d", idx);
    mode = s.mode;
    busy_bad = 0;
    fin = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk({tag, "_done_clr"}, int'(done), 0);
    while (!fin && cyc <= LIMIT) begin
      if (done) begin
        fin = 1'b1;
      end else begin
        if (!busy) busy_bad++;
        if (cyc % P == 2) begin
          k = (cyc - 2) / P;
          chk({tag, "_cd_wait"}, int'({step, c, d}), exp_cd(k));
        end else if (cyc % P == 0) begin
          k = cyc / P - 1;
          chk({tag, "_cd_check"}, int'({step, c, d}), exp_cd(k));
        end
        if (s.abort_at == cyc) begin
          rstn = 1'b0;
          #1;
          chk({tag, "_rst_zero"}, all_outs(), 0);
          @(negedge clk);
          rstn = 1'b1;
          #1;
          chk({tag, "_rst_hold"}, all_outs(), 0);
          return;
        end
        start = (s.pulse_mid && cyc == 5 * P + 2);
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, "_done_cycle"}, cyc, s.exp_cycles);
    chk({tag, "_busy_run"}, busy_bad, 0);
    chk({tag, "_busy_done"}, int'(busy), 0);
    chk({tag, "_pass"}, int'(pass), int'(s.exp_pass));
    chk({tag, "_err"}, int'(err), s.exp_err);
    chk({tag, "_step"}, int'(step), s.exp_step);
    chk({tag, "_fail"}, int'(fail), int'(s.exp_fail));
    repeat (3) @(negedge clk);
    chk({tag, "_held"}, int'({done, err, step}), int'({1'b1, s.exp_err[7:0], s.exp_step[4:0]}));
  endtask

  initial begin
    logic [13:0] c_tab, d_tab;
    logic [7:0]  lf;
    int          ones;
    int          cyc;

    c_tab = 14'b10010101001011;
    d_tab = 14'b11001010100100;
    for (int i = 0; i < 14; i++) vecs[i] = '{i, c_tab[i], d_tab[i]};

    lf = 8'hA5;
    ref_c[0] = 1'b1; ref_d[0] = 1'b0; ref_m[0] = 1'b0;
    for (int k = 1; k < 32; k++) begin
      ref_c[k] = lf[0];
      ref_d[k] = lf[1];
      ref_m[k] = lf[0] ? lf[1] : ref_m[k-1];
      lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[4], lf[7:1]};
    end
    ones = 0;
    for (int k = 0; k < 32; k++) ones += int'(ref_m[k]);

    scens[0] = '{0, 1'b1, 0, 129, 1'b1, 0, 31, 1'b0};
    scens[1] = '{0, 1'b0, 0, 129, 1'b1, 0, 31, 1'b0};
`ifdef DLATCH_BIST_STOP_ON_FAIL_EN
    scens[2] = '{1, 1'b0, 0, 57, 1'b0, 1, 13, 1'b1};
`else
    scens[2] = '{1, 1'b0, 0, 129, 1'b0, ones, 31, 1'b0};
`endif
    scens[3] = '{0, 1'b0, 42, 0, 1'b0, 0, 0, 1'b0};
    scens[4] = '{0, 1'b0, 0, 129, 1'b1, 0, 31, 1'b0};

    mode = 0;
    rstn = 1'b0;
    start = 1'b0;
    start3 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 0);
    chk("reset_outs3", int'({c3, d3, busy3, done3, pass3, err3, step3}), 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_outs", all_outs(), 0);

    // qbar tied to q on a 3-bit counter instance
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cyc = 1;
    while (!done3 && cyc <= LIMIT) begin
      @(negedge clk);
      cyc++;
    end
`ifdef DLATCH_BIST_STOP_ON_FAIL_EN
    chk("tied_cycle", cyc, 5);
    chk("tied_err", int'(err3), 1);
    chk("tied_step", int'(step3), 0);
    chk("tied_fail", int'(fail3), 1);
`else
    chk("tied_cycle", cyc, 129);
    chk("tied_err", int'(err3), 7);
    chk("tied_step", int'(step3), 31);
    chk("tied_fail", int'(fail3), 0);
`endif
    chk("tied_pass", int'(pass3), 0);

    for (int i = 0; i < 5; i++) do_run(scens[i], i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
